// File: rtl/arbitro_escritura_registros.sv
// Register-bank write-port arbiter: A/B writeback handshakes,
// B anti-starvation, and zero-clear sweep of x1..x31.
module arbitro_escritura_registros #(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 3
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              clr_req,
  input  logic              a_valid,
  input  logic [ADDR_W-1:0] a_rd,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [ADDR_W-1:0] b_rd,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  output logic [ADDR_W-1:0] rd,
  output logic [DATA_W-1:0] di,
  output logic              wre,
  output logic              busy
);

  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_WAIT);

  typedef enum logic {
    SWEEP,
    ARB
  } state_t;

  state_t        state;
  logic [4:0]    cnt;
  logic [WW-1:0] b_wait;
  logic          arb;
  logic          b_starved;

  assign arb       = (state == ARB) & ~clr_req;
  assign b_starved = (b_wait == WAIT_MAX);
  assign b_ready   = arb & b_valid & (~a_valid | b_starved);
  assign a_ready   = arb & a_valid & ~b_ready;

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state  <= SWEEP;
      cnt    <= 5'd1;
      b_wait <= '0;
      wre    <= 1'b0;
      rd     <= '0;
      di     <= '0;
      busy   <= 1'b1;
    end else begin
      unique case (state)
        SWEEP: begin
          wre <= 1'b1;
          rd  <= ADDR_W'(cnt);
          di  <= '0;
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) begin
            state <= ARB;
            busy  <= 1'b0;
          end
        end
        ARB: begin
          if (clr_req) begin
            state <= SWEEP;
            cnt   <= 5'd1;
            busy  <= 1'b1;
            wre   <= 1'b0;
          end else begin
            // x0 writes still handshake but never reach the bank
            unique case (1'b1)
              b_ready: begin
                rd  <= b_rd;
                di  <= b_data;
                wre <= (b_rd != '0);
              end
              a_ready: begin
                rd  <= a_rd;
                di  <= a_data;
                wre <= (a_rd != '0);
              end
              default: wre <= 1'b0;
            endcase
            if (b_ready | ~b_valid)
              b_wait <= '0;
            else if (!b_starved)
              b_wait <= b_wait + 1'b1;
          end
        end
        default: state <= SWEEP;
      endcase
    end
  end

endmodule

// File: tb/tb_arbitro_escritura_registros.sv
// Bench for arbitro_escritura_registros: reference model
// compared every cycle plus directed literal checks.
module tb_arbitro_escritura_registros;

  localparam int MW = 3;

  logic        CLK;
  logic        Reset;
  logic        clr_req;
  logic        a_valid;
  logic [4:0]  a_rd;
  logic [31:0] a_data;
  logic        a_ready;
  logic        b_valid;
  logic [4:0]  b_rd;
  logic [31:0] b_data;
  logic        b_ready;
  logic [4:0]  rd;
  logic [31:0] di;
  logic        wre;
  logic        busy;

  int checks = 0;
  int fails  = 0;
  bit run    = 0;

  arbitro_escritura_registros #(
    .ADDR_W(5), .DATA_W(32), .MAX_WAIT(MW)
  ) dut (
    .CLK(CLK), .Reset(Reset), .clr_req(clr_req),
    .a_valid(a_valid), .a_rd(a_rd), .a_data(a_data),
    .a_ready(a_ready),
    .b_valid(b_valid), .b_rd(b_rd), .b_data(b_data),
    .b_ready(b_ready),
    .rd(rd), .di(di), .wre(wre), .busy(busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Model: writes left in the sweep, consecutive B stalls,
  // and the expected registered write port.
  int          m_left  = 31;
  int          m_stall = 0;
  logic        e_wre   = 1'b0;
  logic [4:0]  e_rd    = '0;
  logic [31:0] e_di    = '0;
  logic        e_busy  = 1'b1;

  function automatic bit exp_b();
    return m_left == 0 && !clr_req && b_valid &&
           (!a_valid || m_stall >= MW);
  endfunction

  function automatic bit exp_a();
    return m_left == 0 && !clr_req && a_valid && !exp_b();
  endfunction

  always @(posedge CLK or negedge Reset) begin
    bit gb, ga;
    if (!Reset) begin
      m_left = 31; m_stall = 0;
      e_wre = 0; e_rd = 0; e_di = 0; e_busy = 1;
    end else if (m_left > 0) begin
      e_wre = 1; e_rd = 5'(32 - m_left); e_di = 0;
      m_left--;
      e_busy = (m_left != 0);
    end else if (clr_req) begin
      m_left = 31; e_busy = 1; e_wre = 0;
    end else begin
      gb = exp_b();
      ga = exp_a();
      if (gb) begin
        e_rd = b_rd; e_di = b_data; e_wre = (b_rd != 0);
      end else if (ga) begin
        e_rd = a_rd; e_di = a_data; e_wre = (a_rd != 0);
      end else begin
        e_wre = 0;
      end
      if (b_valid && !gb)
        m_stall = (m_stall < MW) ? m_stall + 1 : MW;
      else
        m_stall = 0;
    end
  end

  always @(negedge CLK) begin
    if (run) begin
      chk("wre", 32'(wre), 32'(e_wre));
      chk("rd", 32'(rd), 32'(e_rd));
      chk("di", di, e_di);
      chk("busy", 32'(busy), 32'(e_busy));
      chk("a_ready", 32'(a_ready), 32'(exp_a()));
      chk("b_ready", 32'(b_ready), 32'(exp_b()));
    end
  end

  logic [31:0] bank [32];
  initial for (int i = 0; i < 32; i++) bank[i] = '0;
  always @(posedge CLK) if (wre) bank[rd] = di;

  task automatic wait_grant(input bit is_b, output int lat);
    bit got = 0;
    lat = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK);
      if (is_b ? b_ready : a_ready) got = 1;
      @(posedge CLK);
      #1;
      if (got) break;
      lat++;
    end
    if (!got) begin
      fails++;
      $display("FAIL grant_timeout: got none expected %s",
               is_b ? "b_ready" : "a_ready");
    end
  endtask

  task automatic req_a(input logic [4:0] r, input logic [31:0] d,
                       output int lat);
    a_rd = r; a_data = d; a_valid = 1;
    wait_grant(0, lat);
    a_valid = 0;
  endtask

  task automatic req_b(input logic [4:0] r, input logic [31:0] d,
                       output int lat);
    b_rd = r; b_data = d; b_valid = 1;
    wait_grant(1, lat);
    b_valid = 0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40; i++) begin
      @(posedge CLK);
      #1;
      if (!busy) break;
    end
    chk("sweep_end", 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int lat;
    bit pat [8];
    Reset = 1; clr_req = 0;
    a_valid = 0; a_rd = 0; a_data = 0;
    b_valid = 0; b_rd = 0; b_data = 0;
    #3 Reset = 0;
    run = 1;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_wre", 32'(wre), 32'd0);
    chk("rst_rd", 32'(rd), 32'd0);
    chk("rst_di", di, 32'd0);
    chk("rst_busy", 32'(busy), 32'd1);

    // requests held during the sweep must not be granted
    a_valid = 1; a_rd = 2; a_data = 32'h22;
    b_valid = 1; b_rd = 4; b_data = 32'h44;
    #1 Reset = 1;
    for (int k = 1; k <= 31; k++) begin
      @(posedge CLK);
      #1;
      chk("sweep_wre", 32'(wre), 32'd1);
      chk("sweep_rd", 32'(rd), 32'(k));
      chk("sweep_di", di, 32'd0);
      chk("sweep_busy", 32'(busy), (k == 31) ? 32'd0 : 32'd1);
      if (k < 31) begin
        chk("sweep_a_ready", 32'(a_ready), 32'd0);
        chk("sweep_b_ready", 32'(b_ready), 32'd0);
      end else begin
        chk("first_grant_a", 32'(a_ready), 32'd1);
        chk("first_grant_b", 32'(b_ready), 32'd0);
        a_valid = 0; b_valid = 0;
      end
    end

    req_a(5'd1, 32'hEAAAAAAA, lat);
    chk("a_latency", 32'(lat), 32'd0);
    chk("a_wre", 32'(wre), 32'd1);
    chk("a_rd", 32'(rd), 32'd1);
    chk("a_di", di, 32'hEAAAAAAA);

    req_b(5'd3, 32'h12345678, lat);
    chk("b_latency", 32'(lat), 32'd0);
    chk("b_wre", 32'(wre), 32'd1);
    chk("b_rd", 32'(rd), 32'd3);
    chk("b_di", di, 32'h12345678);

    req_a(5'd0, 32'hFFFFFFFF, lat);
    chk("x0_latency", 32'(lat), 32'd0);
    chk("x0_wre", 32'(wre), 32'd0);
    @(posedge CLK);
    #1;
    chk("x0_bank", bank[0], 32'd0);
    chk("x1_bank", bank[1], 32'hEAAAAAAA);

    // A A A B A A A B under continuous traffic to the same rd
    pat = '{0, 0, 0, 1, 0, 0, 0, 1};
    a_rd = 7; a_data = 32'hAAAA0007; a_valid = 1;
    b_rd = 7; b_data = 32'hBBBB0007; b_valid = 1;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      chk("prio_b", 32'(b_ready), 32'(pat[i]));
      chk("prio_a", 32'(a_ready), 32'(!pat[i]));
    end
    @(posedge CLK);
    #1;
    a_valid = 0; b_valid = 0;
    chk("prio_last_rd", 32'(rd), 32'd7);
    chk("prio_last_di", di, 32'hBBBB0007);
    @(posedge CLK);
    #1;
    chk("prio_bank7", bank[7], 32'hBBBB0007);

    a_rd = 5; a_data = 32'h00000055; a_valid = 1;
    clr_req = 1;
    @(negedge CLK);
    chk("clr_a_ready", 32'(a_ready), 32'd0);
    @(posedge CLK);
    #1;
    clr_req = 0;
    chk("clr_busy", 32'(busy), 32'd1);
    chk("clr_wre", 32'(wre), 32'd0);
    for (int k = 1; k <= 31; k++) begin
      @(posedge CLK);
      #1;
      chk("clr_sweep_rd", 32'(rd), 32'(k));
      chk("clr_sweep_wre", 32'(wre), 32'd1);
    end
    chk("post_clr_a_ready", 32'(a_ready), 32'd1);
    @(posedge CLK);
    #1;
    a_valid = 0;
    chk("post_clr_wre", 32'(wre), 32'd1);
    chk("post_clr_rd", 32'(rd), 32'd5);
    chk("post_clr_di", di, 32'h00000055);
    chk("post_clr_bank3", bank[3], 32'd0);

    #1 Reset = 0;
    #1;
    chk("areset_wre", 32'(wre), 32'd0);
    chk("areset_rd", 32'(rd), 32'd0);
    chk("areset_busy", 32'(busy), 32'd1);
    @(posedge CLK);
    #2 Reset = 1;
    for (int k = 1; k <= 9; k++) begin
      @(posedge CLK);
      #1;
      chk("mid_sweep_rd", 32'(rd), 32'(k));
    end
    #1 Reset = 0;
    #1;
    chk("mid_sweep_wre", 32'(wre), 32'd0);
    chk("mid_sweep_rd0", 32'(rd), 32'd0);
    chk("mid_sweep_di", di, 32'd0);
    chk("mid_sweep_busy", 32'(busy), 32'd1);
    @(posedge CLK);
    #2 Reset = 1;
    @(posedge CLK);
    #1;
    chk("restart_rd", 32'(rd), 32'd1);
    chk("restart_wre", 32'(wre), 32'd1);
    wait_idle();

    req_a(5'd9, 32'h99999999, lat);
    chk("xfer_wre", 32'(wre), 32'd1);
    #1 Reset = 0;
    #1;
    chk("xfer_rst_wre", 32'(wre), 32'd0);
    chk("xfer_rst_rd", 32'(rd), 32'd0);
    chk("xfer_rst_di", di, 32'd0);
    chk("xfer_rst_busy", 32'(busy), 32'd1);
    @(posedge CLK);
    #2 Reset = 1;
    @(posedge CLK);
    #1;
    chk("xfer_restart_rd", 32'(rd), 32'd1);
    wait_idle();
    repeat (2) @(posedge CLK);
    #1;
    run = 0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
